// File: rtl/m_stopwatch_bcd.sv
// m_stopwatch_bcd: MM:SS.cc BCD stopwatch driven by a 1 ms strobe, with start/stop, lap-freeze and clear buttons
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   tick_ms  : one-cycle 1 ms strobe
//   btn_ss   : start/stop button level (debounced, asynchronous)
//   btn_lap  : lap button level (debounced, asynchronous)
//   btn_clr  : clear button level (debounced, asynchronous)
//   disp     : {min_t, min_o, sec_t, sec_o, cs_t, cs_o}, lap latch while in LAP
//   state    : 00 IDLE, 01 RUN, 10 STOP, 11 LAP
//   running  : high in RUN or LAP
//   ovf      : one-cycle pulse after wrapping from 59:59.99 to 00:00.00
module m_stopwatch_bcd #(
    parameter int TICKS_PER_CS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick_ms,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    output logic [23:0] disp,
    output logic [1:0]  state,
    output logic        running,
    output logic        ovf
);
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] STOP = 2'b10;
    localparam logic [1:0] LAP  = 2'b11;
    // per-digit maximum, index 0 = cs_o ... index 5 = min_t
    localparam logic [5:0][3:0] DMAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
    localparam logic [7:0] DIV_LAST = 8'(TICKS_PER_CS - 1);

    // button vectors: bit 0 ss, bit 1 lap, bit 2 clr
    logic [2:0]      sync1_q, sync2_q, prev_q, ev;
    logic [1:0]      state_q, state_d;
    logic [7:0]      div_q, div_d;
    logic [5:0][3:0] dig_q, dig_d, lap_q, lap_d;
    logic            ovf_q, ovf_d;

    assign ev = sync2_q & ~prev_q;

    // RUN and LAP are exactly the states with bit 0 set
    always_comb begin
        state_d = state_q;
        if (ev[0])
            state_d = state_q[0] ? STOP : RUN;
        else if (ev[1] && state_q[0])
            state_d = (state_q == RUN) ? LAP : RUN;
        else if (ev[2] && state_q == STOP)
            state_d = IDLE;
    end

    always_comb begin
        logic carry;
        div_d = div_q;
        dig_d = dig_q;
        lap_d = lap_q;
        carry = 1'b0;
        if (tick_ms && state_q[0]) begin
            div_d = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;
            carry = (div_q == DIV_LAST);
        end
        for (int i = 0; i < 6; i++) begin
            if (carry)
                dig_d[i] = (dig_q[i] == DMAX[i]) ? 4'd0 : dig_q[i] + 4'd1;
            carry = carry && (dig_q[i] == DMAX[i]);
        end
        // carry out of min_t is the 59:59.99 wrap
        ovf_d = carry;
        if (state_d == LAP && state_q != LAP)
            lap_d = dig_q;
        if (state_d == IDLE) begin
            div_d = '0;
            dig_d = '0;
            lap_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            state_q <= IDLE;
            div_q   <= '0;
            dig_q   <= '0;
            lap_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= {btn_clr, btn_lap, btn_ss};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            div_q   <= div_d;
            dig_q   <= dig_d;
            lap_q   <= lap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign disp    = (state_q == LAP) ? lap_q : dig_q;
    assign state   = state_q;
    assign running = state_q[0];
    assign ovf     = ovf_q;
endmodule

// File: tb/tb_m_stopwatch_bcd.sv
// tb_m_stopwatch_bcd: directed scoreboard bench for m_stopwatch_bcd (instance a: 10 ticks/cs, instance b: 1 tick/cs)
module tb_m_stopwatch_bcd;
    logic        clk = 1'b0, clk_en = 1'b1, rst_n = 1'b0;
    logic        tick_a = 1'b0, tick_b = 1'b0;
    logic        btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;
    logic [23:0] disp_a, disp_b;
    logic [1:0]  state_a, state_b;
    logic        run_a, run_b, ovf_a, ovf_b;
    int          checks = 0, errors = 0;

    typedef struct {
        string       tag;
        bit          inst;
        int          sig;
        logic [23:0] exp;
    } exp_t;
    exp_t sb[$];

    m_stopwatch_bcd #(.TICKS_PER_CS(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_a),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .disp(disp_a), .state(state_a), .running(run_a), .ovf(ovf_a)
    );

    m_stopwatch_bcd #(.TICKS_PER_CS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .tick_ms(tick_b),
        .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
        .disp(disp_b), .state(state_b), .running(run_b), .ovf(ovf_b)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic logic [23:0] observe(input bit inst, input int sig);
        case (sig)
            0:       return inst ? disp_b : disp_a;
            1:       return {22'd0, inst ? state_b : state_a};
            2:       return {23'd0, inst ? run_b : run_a};
            default: return {23'd0, inst ? ovf_b : ovf_a};
        endcase
    endfunction

    task automatic chk(input string tag, input logic [23:0] o, input logic [23:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic want(input string tag, input bit inst, input int sig, input logic [23:0] e);
        sb.push_back('{tag, inst, sig, e});
    endtask

    task automatic want4(input string tag, input bit inst, input logic [23:0] d, input logic [1:0] st);
        want({tag, "_disp"}, inst, 0, d);
        want({tag, "_state"}, inst, 1, {22'd0, st});
        want({tag, "_running"}, inst, 2, {23'd0, (st == 2'b01 || st == 2'b11)});
        want({tag, "_ovf"}, inst, 3, 24'd0);
    endtask

    task automatic check_all();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, observe(x.inst, x.sig), x.exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ticks(input bit inst, input int n);
        if (inst) tick_b = 1'b1;
        else tick_a = 1'b1;
        cyc(n);
        tick_a = 1'b0;
        tick_b = 1'b0;
    endtask

    // mask bit 0 ss, 1 lap, 2 clr; tk puts a tick on both instances in the event cycle
    task automatic press(input logic [2:0] m, input bit tk);
        {btn_clr, btn_lap, btn_ss} = m;
        cyc(2);
        if (tk) begin
            tick_a = 1'b1;
            tick_b = 1'b1;
        end
        cyc(1);
        tick_a = 1'b0;
        tick_b = 1'b0;
        {btn_clr, btn_lap, btn_ss} = 3'b000;
        cyc(3);
    endtask

    initial begin
        int changes, at;
        logic [1:0] last;
        cyc(2);
        want4("rst_a", 0, 24'h000000, 2'b00);
        want4("rst_b", 1, 24'h000000, 2'b00);
        check_all();
        rst_n = 1'b1;
        cyc(2);

        // asynchronous reset mid-RUN with the clock halted
        press(3'b001, 0);
        ticks(1, 5);
        want4("pre_arst_b", 1, 24'h000005, 2'b01);
        check_all();
        clk_en = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        want4("arst_a", 0, 24'h000000, 2'b00);
        want4("arst_b", 1, 24'h000000, 2'b00);
        check_all();
        #3 rst_n = 1'b1;
        clk_en = 1'b1;
        cyc(2);

        // basic count and stop
        press(3'b001, 0);
        want4("start", 0, 24'h000000, 2'b01);
        check_all();
        ticks(0, 1000);
        want4("count1000", 0, 24'h000100, 2'b01);
        check_all();
        press(3'b001, 0);
        ticks(0, 500);
        want4("stopped", 0, 24'h000100, 2'b10);
        check_all();
        press(3'b100, 0);
        want4("clear", 0, 24'h000000, 2'b00);
        check_all();

        // lap freeze
        press(3'b001, 0);
        ticks(0, 250);
        want4("run250", 0, 24'h000025, 2'b01);
        check_all();
        press(3'b010, 0);
        want4("lap_enter", 0, 24'h000025, 2'b11);
        check_all();
        ticks(0, 300);
        want4("lap_frozen", 0, 24'h000025, 2'b11);
        check_all();
        press(3'b010, 0);
        want4("lap_leave", 0, 24'h000055, 2'b01);
        check_all();

        // priority and ignored events
        press(3'b011, 0);
        want4("ss_lap", 0, 24'h000055, 2'b10);
        check_all();
        press(3'b001, 0);
        press(3'b100, 0);
        want4("clr_in_run", 0, 24'h000055, 2'b01);
        check_all();
        press(3'b001, 0);
        press(3'b100, 1);
        want4("clr_tick", 0, 24'h000000, 2'b00);
        check_all();

        // held button gives one event, re-press after a one-cycle release gives another
        changes = 0;
        at = 0;
        last = state_a;
        btn_ss = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            cyc(1);
            if (state_a !== last) begin
                changes++;
                if (at == 0) at = k;
                last = state_a;
            end
        end
        chk("hold_one_event", 24'(changes), 24'd1);
        chk("hold_latency", {23'd0, at >= 2 && at <= 3}, 24'd1);
        want4("hold_state", 0, 24'h000000, 2'b01);
        check_all();
        btn_ss = 1'b0;
        cyc(1);
        btn_ss = 1'b1;
        changes = 0;
        for (int k = 1; k <= 10; k++) begin
            cyc(1);
            if (state_a !== last) begin
                changes++;
                last = state_a;
            end
        end
        btn_ss = 1'b0;
        cyc(3);
        chk("repress_event", 24'(changes), 24'd1);
        want4("repress_state", 0, 24'h000000, 2'b10);
        check_all();

        // wrap at 59:59.99 on the 1-tick instance, preloaded near the end to keep the run short
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        press(3'b001, 0);
        press(3'b001, 0);
        force dut_b.dig_q = 24'h595900;
        cyc(1);
        release dut_b.dig_q;
        press(3'b001, 0);
        want4("preload", 1, 24'h595900, 2'b01);
        check_all();
        ticks(1, 99);
        want4("at_max", 1, 24'h595999, 2'b01);
        check_all();
        ticks(1, 1);
        want("wrap_disp", 1, 0, 24'h000000);
        want("wrap_ovf", 1, 3, 24'd1);
        want("wrap_state", 1, 1, 24'd1);
        check_all();
        cyc(1);
        want4("after_wrap", 1, 24'h000000, 2'b01);
        check_all();

        // minute carry, tick counted on a stopping edge, tick discarded on clear
        press(3'b001, 0);
        force dut_b.dig_q = 24'h095999;
        cyc(1);
        release dut_b.dig_q;
        press(3'b001, 0);
        ticks(1, 1);
        want4("min_carry", 1, 24'h100000, 2'b01);
        check_all();
        press(3'b001, 1);
        want4("stop_tick", 1, 24'h100001, 2'b10);
        check_all();
        press(3'b100, 1);
        want4("clr_tick_b", 1, 24'h000000, 2'b00);
        check_all();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
